multi_space_meter: RTL and testbench

//  Multi-space parking meter core; next generation of the single-space second counter.

---
 rtl/multi_space_meter.sv | 225 ++++++++++++++++++++++
 tb/tb_multi_space_meter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_space_meter.sv
// Multi-space parking meter core with per-space paid-time countdown, coin credit and violation count.
// Latency: sel_secs/sel_state one cycle after state update; parked edges act one cycle after input change.
// Backpressure: none; all inputs are one-cycle pulses or levels. PM_GRACE_EN adds a grace window before expiry.
module multi_space_meter #(
    parameter int NUM_SPACES = 4,
    parameter int SEC_W      = 12,
    parameter int MAX_SECS   = 3599,
    parameter int ADD_SMALL  = 60,
    parameter int ADD_LARGE  = 300,
    parameter int GRACE_SECS = 10,
    parameter int SEL_W      = (NUM_SPACES > 1) ? $clog2(NUM_SPACES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_1hz_i,
    input  logic [NUM_SPACES-1:0] parked_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  add_small_i,
    input  logic                  add_large_i,
    input  logic                  clear_i,
    output logic [SEC_W-1:0]      sel_secs_o,
    output logic [1:0]            sel_state_o,
    output logic [NUM_SPACES-1:0] expired_o,
    output logic [NUM_SPACES-1:0] expire_pls_o,
    output logic [7:0]            viol_cnt_o
);

    typedef enum logic [1:0] {
        ST_VACANT  = 2'd0,
        ST_PAID    = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_GRACE   = 2'd3
    } state_e;

    localparam logic [SEC_W:0] MAX_W   = (SEC_W+1)'(MAX_SECS);
    localparam logic [SEC_W:0] SMALL_W = (SEC_W+1)'(ADD_SMALL);
    localparam logic [SEC_W:0] LARGE_W = (SEC_W+1)'(ADD_LARGE);

    if (MAX_SECS >= 2**SEC_W || GRACE_SECS < 0) begin : g_cfg_err
        $error("multi_space_meter: MAX_SECS must fit SEC_W and GRACE_SECS must be >= 0");
    end

    state_e                state_q [NUM_SPACES];
    state_e                state_d [NUM_SPACES];
    logic [SEC_W-1:0]      cnt_q   [NUM_SPACES];
    logic [SEC_W-1:0]      cnt_d   [NUM_SPACES];
    logic [NUM_SPACES-1:0] parked_q;
    logic [NUM_SPACES-1:0] expired_q, expired_d;
    logic [NUM_SPACES-1:0] pls_q, pls_d;
    logic [7:0]            viol_q, viol_d;
    logic [SEC_W-1:0]      sel_secs_q, sel_secs_d;
    logic [1:0]            sel_state_q, sel_state_d;

`ifdef PM_GRACE_EN
    localparam int GR_W = (GRACE_SECS > 0) ? $clog2(GRACE_SECS + 1) : 1;
    logic [GR_W-1:0]       grace_q [NUM_SPACES];
    logic [GR_W-1:0]       grace_d [NUM_SPACES];
`endif

    logic             sel_ok;
    logic             hit, clr, has_add, rise, fall, enter_exp;
    logic [SEC_W:0]   add_amt, dec, capped, vac_cnt;
    logic [4:0]       npls;
    logic [8:0]       viol_sum;

    always_comb begin
        sel_ok    = int'(sel_i) < NUM_SPACES;
        hit       = 1'b0;
        clr       = 1'b0;
        has_add   = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        enter_exp = 1'b0;
        add_amt   = '0;
        dec       = '0;
        capped    = '0;
        vac_cnt   = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            hit       = sel_ok && (int'(sel_i) == i);
            clr       = hit && clear_i;
            add_amt   = '0;
            if (hit && !clear_i) begin
                if (add_large_i)      add_amt = LARGE_W;
                else if (add_small_i) add_amt = SMALL_W;
            end
            has_add   = (add_amt != '0);
            rise      = parked_i[i] & ~parked_q[i];
            fall      = ~parked_i[i] & parked_q[i];
            // Decrement before the add so a same-cycle coin rescues a space reaching zero.
            dec       = {1'b0, cnt_q[i]};
            if (state_q[i] == ST_PAID && tick_1hz_i && cnt_q[i] != '0)
                dec = dec - 1'b1;
            capped    = ((dec + add_amt) > MAX_W) ? MAX_W : (dec + add_amt);
            vac_cnt   = clr ? '0 : capped;
            enter_exp = 1'b0;

            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef PM_GRACE_EN
            grace_d[i] = grace_q[i];
`endif
            if (fall) begin
                state_d[i] = ST_VACANT;
                cnt_d[i]   = '0;
`ifdef PM_GRACE_EN
                grace_d[i] = '0;
`endif
            end else begin
                case (state_q[i])
                    ST_VACANT: begin
                        cnt_d[i] = vac_cnt[SEC_W-1:0];
                        if (rise) begin
                            if (vac_cnt != '0) state_d[i] = ST_PAID;
                            else               enter_exp  = 1'b1;
                        end
                    end
                    ST_PAID: begin
                        if (clr) begin
                            cnt_d[i]  = '0;
                            enter_exp = 1'b1;
                        end else begin
                            cnt_d[i] = capped[SEC_W-1:0];
                            if (capped == '0) enter_exp = 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        if (has_add) begin
                            cnt_d[i]   = capped[SEC_W-1:0];
                            state_d[i] = ST_PAID;
                        end
                    end
`ifdef PM_GRACE_EN
                    ST_GRACE: begin
                        if (has_add) begin
                            cnt_d[i]   = capped[SEC_W-1:0];
                            state_d[i] = ST_PAID;
                            grace_d[i] = '0;
                        end else if (tick_1hz_i) begin
                            if (grace_q[i] <= GR_W'(1)) begin
                                state_d[i] = ST_EXPIRED;
                                grace_d[i] = '0;
                            end else begin
                                grace_d[i] = grace_q[i] - 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state_d[i] = ST_VACANT;
                        cnt_d[i]   = '0;
                    end
                endcase
            end

            if (enter_exp) begin
`ifdef PM_GRACE_EN
                state_d[i] = ST_GRACE;
                grace_d[i] = GR_W'(GRACE_SECS);
`else
                state_d[i] = ST_EXPIRED;
`endif
            end

            expired_d[i] = (state_d[i] == ST_EXPIRED);
            pls_d[i]     = expired_d[i] & ~expired_q[i];
        end
    end

    // Several spaces can expire on the same edge, so count them all at once.
    always_comb begin
        npls = '0;
        for (int i = 0; i < NUM_SPACES; i++)
            npls = npls + 5'(pls_d[i]);
        viol_sum = {1'b0, viol_q} + 9'(npls);
        viol_d   = (viol_sum > 9'd255) ? 8'd255 : viol_sum[7:0];
    end

    always_comb begin
        sel_secs_d  = '0;
        sel_state_d = ST_VACANT;
        if (sel_ok) begin
            sel_secs_d  = cnt_q[sel_i];
            sel_state_d = state_q[sel_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SPACES; i++) begin
                state_q[i] <= ST_VACANT;
                cnt_q[i]   <= '0;
`ifdef PM_GRACE_EN
                grace_q[i] <= '0;
`endif
            end
            parked_q    <= '0;
            expired_q   <= '0;
            pls_q       <= '0;
            viol_q      <= '0;
            sel_secs_q  <= '0;
            sel_state_q <= ST_VACANT;
        end else begin
            for (int i = 0; i < NUM_SPACES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef PM_GRACE_EN
                grace_q[i] <= grace_d[i];
`endif
            end
            parked_q    <= parked_i;
            expired_q   <= expired_d;
            pls_q       <= pls_d;
            viol_q      <= viol_d;
            sel_secs_q  <= sel_secs_d;
            sel_state_q <= sel_state_d;
        end
    end

    assign sel_secs_o   = sel_secs_q;
    assign sel_state_o  = sel_state_q;
    assign expired_o    = expired_q;
    assign expire_pls_o = pls_q;
    assign viol_cnt_o   = viol_q;

endmodule

// File: tb/tb_multi_space_meter.sv
// Scoreboard bench for multi_space_meter: directed stimulus pushes expected readback, a negedge monitor compares.
// Latency: each expectation is pushed after two settle cycles; Backpressure: none.
module tb_multi_space_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  parked = 4'b0;
    logic [1:0]  sel = 2'd0;
    logic        add_s = 1'b0, add_l = 1'b0, clr = 1'b0;
    logic [11:0] sel_secs;
    logic [1:0]  sel_state;
    logic [3:0]  expired, expire_pls;
    logic [7:0]  viol_cnt;

    multi_space_meter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_1hz_i   (tick),
        .parked_i     (parked),
        .sel_i        (sel),
        .add_small_i  (add_s),
        .add_large_i  (add_l),
        .clear_i      (clr),
        .sel_secs_o   (sel_secs),
        .sel_state_o  (sel_state),
        .expired_o    (expired),
        .expire_pls_o (expire_pls),
        .viol_cnt_o   (viol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    secs;
        int    st;
        int    expv;
        int    viol;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pls_seen = 0;

    function automatic void chk(string nm, string fld, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s got %0d want %0d", nm, fld, got, want);
        end
    endfunction

    // Monitor: tallies pulses every cycle and checks readback whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            pls_seen = pls_seen + $countones(expire_pls);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "sel_secs",  int'(sel_secs),  e.secs);
                chk(e.nm, "sel_state", int'(sel_state), e.st);
                chk(e.nm, "expired",   int'(expired),   e.expv);
                chk(e.nm, "viol_cnt",  int'(viol_cnt),  e.viol);
                chk(e.nm, "pulses",    pls_seen,        e.viol);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic press(input logic sm, input logic lg, input logic cl);
        add_s = sm; add_l = lg; clr = cl;
        cyc();
        add_s = 1'b0; add_l = 1'b0; clr = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic expect_out(input string nm, input int secs, input int st,
                              input int expv, input int viol);
        exp_t e;
        idle(2);
        e.nm = nm; e.secs = secs; e.st = st; e.expv = expv; e.viol = viol;
        q.push_back(e);
        cyc();
    endtask

    initial begin
        // Reset state
        idle(1);
        expect_out("in_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_out("post_reset", 0, 0, 0, 0);

        // Space 0 countdown to 125 s, then asynchronous reset mid-count
        sel = 2'd0;
        repeat (3) press(1'b1, 1'b0, 1'b0);
        parked[0] = 1'b1;
        idle(1);
        ticks(55);
        expect_out("s0_at_125", 125, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        parked[0] = 1'b0;
        expect_out("reset_mid", 0, 0, 0, 0);
        rst_n = 1'b1;
        expect_out("after_reset_mid", 0, 0, 0, 0);

        // Space 1: prepay 120 s, park, count down to expiry
        sel = 2'd1;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        expect_out("s1_prepay", 120, 0, 0, 0);
        parked[1] = 1'b1;
        expect_out("s1_paid", 120, 1, 0, 0);
        ticks(119);
        expect_out("s1_at_1", 1, 1, 0, 0);
        ticks(1);
        expect_out("s1_expired", 0, 2, 4'b0010, 1);

        // Space 2: credit saturation while vacant
        sel = 2'd2;
        repeat (11) press(1'b0, 1'b1, 1'b0);
        expect_out("s2_3300", 3300, 0, 4'b0010, 1);
        press(1'b0, 1'b1, 1'b0);
        expect_out("s2_sat", 3599, 0, 4'b0010, 1);
        press(1'b0, 1'b1, 1'b0);
        expect_out("s2_sat_hold", 3599, 0, 4'b0010, 1);

        // Space 1: both adds -> large only; clear in PAID expires; clear beats add
        sel = 2'd1;
        press(1'b1, 1'b1, 1'b0);
        expect_out("s1_both_adds", 300, 1, 0, 1);
        press(1'b0, 1'b0, 1'b1);
        expect_out("s1_clear_paid", 0, 2, 4'b0010, 2);
        press(1'b0, 1'b1, 1'b1);
        expect_out("s1_clear_beats_add", 0, 2, 4'b0010, 2);

        // Space 3: departure while PAID at 200 s
        sel = 2'd3;
        press(1'b0, 1'b1, 1'b0);
        parked[3] = 1'b1;
        idle(1);
        ticks(100);
        expect_out("s3_at_200", 200, 1, 4'b0010, 2);
        parked[3] = 1'b0;
        expect_out("s3_departed", 0, 0, 4'b0010, 2);

        // Space 0: tick and coin on the same cycle at 1 s
        sel = 2'd0;
        press(1'b1, 1'b0, 1'b0);
        parked[0] = 1'b1;
        idle(1);
        ticks(59);
        expect_out("s0_at_1", 1, 1, 4'b0010, 2);
        tick = 1'b1; add_s = 1'b1;
        cyc();
        tick = 1'b0; add_s = 1'b0;
        expect_out("s0_tick_add", 60, 1, 4'b0010, 2);

        // Clear vacant space 2, then spaces 2 and 3 arrive unpaid on the same cycle
        sel = 2'd2;
        press(1'b0, 1'b0, 1'b1);
        expect_out("s2_clear_vacant", 0, 0, 4'b0010, 2);
        parked[2] = 1'b1;
        parked[3] = 1'b1;
        expect_out("s23_double_expiry", 0, 2, 4'b1110, 4);
        sel = 2'd3;
        expect_out("s3_expired_read", 0, 2, 4'b1110, 4);

        idle(2);
        chk("drain", "queue_size", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
